ipg_memq_tx: RTL and testbench
==============================

# ipg_memq_tx

Reply-chunk queue and IPG slot inserter that sits directly downstream of the read-request processor. It buffers 64-bit reply chunks (byte 0 = control code, bytes 7:1 = payload) into a message-framed FIFO. It releases a message to the transmit path only once the whole message is stored, one chunk per idle-slot grant. Upstream does not honour backpressure, so overflow is handled by dropping whole messages, never partial ones.

## Interface

- DEPTH, 16, FIFO entries; power of 2, ≥ 2
- ADDR_W, 4, log2(DEPTH)
- CNT_W, 16, width of drop counter

- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- memq_data  in  64  reply chunk from processor
- memq_write  in  1  chunk valid this cycle
- memq_last  in  1  qualifies memq_write: final chunk of message
- memq_full  out  1  level == DEPTH (advisory)
- tx_slot  in  1  transmit path grants one idle IPG slot this cycle
- tx_ipg_data  out  64  chunk to insert
- tx_ipg_valid  out  1  tx_ipg_data valid (one cycle per chunk)
- tx_ipg_last  out  1  with tx_ipg_valid: last chunk of message
- level  out  ADDR_W+1  stored entries, including incomplete message
- drop_count  out  CNT_W  messages dropped; saturates at all-ones

## Operation

- Storage: DEPTH × 65 bits (data + last). Pointers are ADDR_W+1 bits wide with wrap bit. level = wr_ptr − rd_ptr.
- msg_start: wr_ptr value at the first chunk of the message currently being written.
- msg_cnt: count of complete messages stored. It increments on a write with memq_last and decrements on a pop with last. Increment and decrement in the same cycle leave it unchanged.
- Write, not dropping, level < DEPTH (after same-cycle pop): store the entry and increment wr_ptr. If last, set msg_start = new wr_ptr.
- Overflow (write while full, no same-cycle pop): set wr_ptr = msg_start, discarding the partial message, and enter DROP mode. The chunk is discarded.
- DROP mode: discard all writes. On a write with memq_last, leave DROP mode and increment drop_count once per message.
- An overflow on the last chunk itself drops that message and does not enter DROP mode. drop_count still increments.
- A message longer than DEPTH is always dropped; this is the no-deadlock guarantee.
- Read FSM:
  - IDLE: if tx_slot and msg_cnt > 0, pop the head. If head.last, stay IDLE; else go to SEND.
  - SEND: if tx_slot, pop the head. If head.last, go to IDLE.
  - Once begun, a message is never interrupted; chunks of different messages are never interleaved.
- Rollback never touches entries being read, because reads only cover complete messages.
- Data is passed through unmodified, including byte 0.

## Timing

- Reset values: tx_ipg_data = 0, tx_ipg_valid = 0, tx_ipg_last = 0, memq_full = 0, level = 0, drop_count = 0. Pointers, msg_start, and msg_cnt are 0; FSM in IDLE; DROP mode clear.
- Reset mid-message discards all stored and in-flight data. Outputs are 0 from the reset assertion edge.
- Pop: tx_slot sampled at edge E. The output registers load the head at E, so tx_ipg_valid is high for the cycle after E. With no pop, tx_ipg_valid = 0.
- Latency: a last chunk written at edge N updates msg_cnt at N. The earliest pop is at edge N+1, with tx_ipg_valid high after N+1.
- Continuous tx_slot streams one chunk per cycle with no bubbles.
- level and memq_full are registered and reflect writes and pops of the preceding edge. A simultaneous write and pop leave level unchanged.
- A write at level == DEPTH with a same-cycle pop is accepted, not treated as overflow.

## Test plan

- Store-and-forward: write 10 chunks (0x…01 to 0x…0A, last on the 10th) with tx_slot held high. tx_ipg_valid stays 0 until the edge after the last write, then is high for 10 consecutive cycles in order, with tx_ipg_last on chunk 10. Afterwards level = 0.
- Slot gating: one 3-chunk message stored, tx_slot pulsed every 3rd cycle. Exactly one chunk follows each pulse and FSM passes through SEND. A second complete message does not start until the first has emitted its last chunk.
- Overflow: DEPTH = 16, tx_slot low, write two 10-chunk messages back to back. The second message rolls back at its 7th chunk. Final level = 10, drop_count = 1, and memq_full deasserts after rollback. Then raise tx_slot: exactly 10 chunks emit, all from message 1.
- Oversize: a 20-chunk message with tx_slot high. Nothing is output, drop_count increments, and a following 2-chunk message transmits normally.
- Full with concurrent pop: fill 16 entries (two 8-chunk messages), then write and tx_slot in the same cycle. The write is accepted, level stays 16, and drop_count stays 0.
- Reset mid-SEND: assert reset after 4 of 10 chunks have been emitted. Outputs are 0 immediately, level = 0, and a fresh message after reset transmits correctly.

Source files
------------

// File: rtl/ipg_memq_tx.sv
// ipg_memq_tx: message-framed reply-chunk FIFO that releases whole messages into idle IPG slots.
// Overflow rolls the write pointer back to the message start, so partial messages are never sent.
module ipg_memq_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       memq_data,
    input  logic              memq_write,
    input  logic              memq_last,
    output logic              memq_full,
    input  logic              tx_slot,
    output logic [63:0]       tx_ipg_data,
    output logic              tx_ipg_valid,
    output logic              tx_ipg_last,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  drop_count
);
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [64:0]       mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, msg_start_q, msg_start_d;
    logic [ADDR_W:0]   msg_cnt_q, msg_cnt_d, level_q, level_d, level_cur;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;
    logic [63:0]       data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d, full_q, full_d, drop_q, drop_d;
    state_t            state_q, state_d;
    logic [64:0]       head;
    logic              pop, space, wr_en, ovf, inc, dec, bump;

    always_comb begin
        level_cur = wr_ptr_q - rd_ptr_q;
        head = mem_q[rd_ptr_q[ADDR_W-1:0]];
        // msg_cnt still counts the message being sent, so this also covers SEND
        pop = tx_slot && msg_cnt_q != '0;
        space = level_cur != FULL_LVL || pop;
        wr_en = memq_write && !drop_q && space;
        ovf = memq_write && !drop_q && !space;
        inc = wr_en && memq_last;
        dec = pop && head[64];
        bump = memq_write && memq_last && (drop_q || ovf);
        wr_ptr_d = ovf ? msg_start_q : wr_ptr_q + (ADDR_W+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(pop);
        msg_start_d = inc ? wr_ptr_q + 1'b1 : msg_start_q;
        drop_d = ovf ? !memq_last : drop_q && !(memq_write && memq_last);
        drop_count_d = (bump && drop_count_q != '1) ? drop_count_q + 1'b1 : drop_count_q;
        msg_cnt_d = (inc && !dec) ? msg_cnt_q + 1'b1 : (dec && !inc) ? msg_cnt_q - 1'b1 : msg_cnt_q;
        state_d = (state_q == IDLE) ? ((pop && !head[64]) ? SEND : IDLE)
                                    : ((pop && head[64]) ? IDLE : SEND);
        valid_d = pop;
        data_d = pop ? head[63:0] : '0;
        last_d = pop && head[64];
        level_d = wr_ptr_d - rd_ptr_d;
        full_d = level_d == FULL_LVL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            msg_start_q  <= '0;
            msg_cnt_q    <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            state_q      <= IDLE;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            msg_start_q  <= msg_start_d;
            msg_cnt_q    <= msg_cnt_d;
            level_q      <= level_d;
            full_q       <= full_d;
            drop_q       <= drop_d;
            drop_count_q <= drop_count_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            state_q      <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {memq_last, memq_data};
    end

    assign memq_full    = full_q;
    assign level        = level_q;
    assign drop_count   = drop_count_q;
    assign tx_ipg_data  = data_q;
    assign tx_ipg_valid = valid_q;
    assign tx_ipg_last  = last_q;
endmodule

// File: tb/tb_ipg_memq_tx.sv
// tb_ipg_memq_tx: directed store-and-forward, gating, overflow, oversize, full-pop and reset checks.
module tb_ipg_memq_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] memq_data = '0;
    logic        memq_write = 1'b0, memq_last = 1'b0, tx_slot = 1'b0;
    logic        memq_full, tx_ipg_valid, tx_ipg_last;
    logic [63:0] tx_ipg_data;
    logic [4:0]  level;
    logic [15:0] drop_count;
    int          n_chk = 0, n_err = 0;
    logic        any_v;

    ipg_memq_tx #(.DEPTH(16), .ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .memq_data(memq_data), .memq_write(memq_write),
        .memq_last(memq_last), .memq_full(memq_full), .tx_slot(tx_slot),
        .tx_ipg_data(tx_ipg_data), .tx_ipg_valid(tx_ipg_valid), .tx_ipg_last(tx_ipg_last),
        .level(level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] d, input logic l);
        memq_write = 1'b1;
        memq_data = d;
        memq_last = l;
        cyc();
        memq_write = 1'b0;
        memq_last = 1'b0;
    endtask

    task automatic expect_chunk(input string tag, input logic [63:0] d, input logic l);
        chk({tag, "_valid"}, 64'(tx_ipg_valid), 64'd1);
        chk({tag, "_data"}, tx_ipg_data, d);
        chk({tag, "_last"}, 64'(tx_ipg_last), 64'(l));
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_valid", 64'(tx_ipg_valid), 0);
        chk("rst_last", 64'(tx_ipg_last), 0);
        chk("rst_data", tx_ipg_data, 0);
        chk("rst_full", 64'(memq_full), 0);
        chk("rst_level", 64'(level), 0);
        chk("rst_drop", 64'(drop_count), 0);
        reset = 1'b0;
        cyc();

        // store-and-forward with slot held high
        tx_slot = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wr(64'(i), i == 10);
            chk("sf_hold", 64'(tx_ipg_valid), 0);
        end
        for (int k = 1; k <= 10; k++) begin
            cyc();
            expect_chunk("sf", 64'(k), k == 10);
        end
        cyc();
        chk("sf_after_valid", 64'(tx_ipg_valid), 0);
        chk("sf_level", 64'(level), 0);

        // slot gating over two stored messages
        tx_slot = 1'b0;
        for (int i = 1; i <= 3; i++) wr(64'h20 + 64'(i), i == 3);
        for (int i = 1; i <= 2; i++) wr(64'h30 + 64'(i), i == 2);
        for (int p = 0; p < 5; p++) begin
            tx_slot = 1'b1;
            cyc();
            tx_slot = 1'b0;
            expect_chunk("gate", p < 3 ? 64'h21 + 64'(p) : 64'h31 + 64'(p - 3), p == 2 || p == 4);
            if (p == 0) chk("gate_send", 64'(dut.state_q), 64'd1);
            cyc();
            chk("gate_idle", 64'(tx_ipg_valid), 0);
            cyc();
        end

        // overflow: second message rolls back at its 7th chunk
        for (int i = 1; i <= 10; i++) wr(64'h40 + 64'(i), i == 10);
        for (int i = 1; i <= 10; i++) begin
            wr(64'h50 + 64'(i), i == 10);
            if (i == 6) begin
                chk("ovf_level16", 64'(level), 16);
                chk("ovf_full", 64'(memq_full), 1);
            end
            if (i == 7) begin
                chk("ovf_rollback", 64'(level), 10);
                chk("ovf_full_clr", 64'(memq_full), 0);
            end
        end
        chk("ovf_level", 64'(level), 10);
        chk("ovf_drop", 64'(drop_count), 1);
        tx_slot = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            expect_chunk("ovf_out", 64'h40 + 64'(k), k == 10);
        end
        cyc();
        chk("ovf_out_end", 64'(tx_ipg_valid), 0);

        // oversize message with slot high
        any_v = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wr(64'h60 + 64'(i), i == 20);
            any_v |= tx_ipg_valid;
        end
        cyc();
        any_v |= tx_ipg_valid;
        chk("big_no_out", 64'(any_v), 0);
        chk("big_drop", 64'(drop_count), 2);
        chk("big_level", 64'(level), 0);
        wr(64'h71, 1'b0);
        wr(64'h72, 1'b1);
        chk("big_next_hold", 64'(tx_ipg_valid), 0);
        cyc();
        expect_chunk("big_next1", 64'h71, 1'b0);
        cyc();
        expect_chunk("big_next2", 64'h72, 1'b1);

        // full with concurrent pop
        tx_slot = 1'b0;
        for (int i = 1; i <= 8; i++) wr(64'h80 + 64'(i), i == 8);
        for (int i = 1; i <= 8; i++) wr(64'h90 + 64'(i), i == 8);
        chk("fp_level16", 64'(level), 16);
        chk("fp_full", 64'(memq_full), 1);
        tx_slot = 1'b1;
        wr(64'hA1, 1'b1);
        chk("fp_level", 64'(level), 16);
        chk("fp_drop", 64'(drop_count), 2);
        expect_chunk("fp_first", 64'h81, 1'b0);
        for (int k = 2; k <= 17; k++) begin
            cyc();
            expect_chunk("fp_drain", k <= 8 ? 64'h80 + 64'(k) : k <= 16 ? 64'h90 + 64'(k - 8) : 64'hA1,
                         k == 8 || k >= 16);
        end
        cyc();
        chk("fp_level_end", 64'(level), 0);

        // reset mid-SEND
        tx_slot = 1'b0;
        for (int i = 1; i <= 10; i++) wr(64'hB0 + 64'(i), i == 10);
        tx_slot = 1'b1;
        for (int k = 1; k <= 4; k++) cyc();
        expect_chunk("rs_pre", 64'hB4, 1'b0);
        reset = 1'b1;
        tx_slot = 1'b0;
        #1;
        chk("rs_valid", 64'(tx_ipg_valid), 0);
        chk("rs_data", tx_ipg_data, 0);
        chk("rs_level", 64'(level), 0);
        cyc();
        reset = 1'b0;
        cyc();
        wr(64'hC1, 1'b0);
        wr(64'hC2, 1'b1);
        tx_slot = 1'b1;
        cyc();
        expect_chunk("rs_new1", 64'hC1, 1'b0);
        cyc();
        expect_chunk("rs_new2", 64'hC2, 1'b1);
        cyc();
        chk("rs_end_valid", 64'(tx_ipg_valid), 0);
        chk("rs_end_level", 64'(level), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
